// File: rtl/sdram_cmd_fifo.sv
// sdram_cmd_fifo
//   Host-side command queue feeding the SDRAM command pipeline stage.
//   Host requests (write flag, address, write data) are accepted on a
//   valid/ready handshake and presented in order at the head. The
//   controller FSM consumes the head with a one-cycle cmd_accept pulse.
//   After every pop, cmd_valid is held low for HOLDOFF cycles so the
//   downstream sampling stage always sees the new head before it is
//   marked valid.
//
// Ports
//   clk         : single clock, rising edge
//   rst         : synchronous active-high reset
//   host_valid  : host request present
//   host_ready  : queue can accept this cycle (registered count only)
//   host_write  : 1 = write, 0 = read
//   host_addr   : request address {row, col, bank} packed
//   host_wdata  : write data (stored for reads too)
//   cmd_valid   : head entry valid to controller
//   cmd_write   : head write flag
//   cmd_addr    : head address
//   cmd_wdata   : head write data
//   cmd_accept  : one-cycle pulse, head consumed
//   fill_level  : entries currently stored
//   accept_err  : sticky, cmd_accept seen while cmd_valid was low
module sdram_cmd_fifo #(
    parameter int ROW_BITS  = 13,
    parameter int COL_BITS  = 9,
    parameter int BANK_BITS = 2,
    parameter int DEPTH     = 4,
    parameter int HOLDOFF   = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  host_valid,
    output logic                                  host_ready,
    input  logic                                  host_write,
    input  logic [ROW_BITS+COL_BITS+BANK_BITS-1:0] host_addr,
    input  logic [15:0]                           host_wdata,
    output logic                                  cmd_valid,
    output logic                                  cmd_write,
    output logic [ROW_BITS+COL_BITS+BANK_BITS-1:0] cmd_addr,
    output logic [15:0]                           cmd_wdata,
    input  logic                                  cmd_accept,
    output logic [$clog2(DEPTH):0]                fill_level,
    output logic                                  accept_err
);

    localparam int ADDR_W  = ROW_BITS + COL_BITS + BANK_BITS;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_W + 16;

    // Storage is cleared on reset, so it is built from plain flops rather
    // than a block RAM; the head is a mux of those flops.
    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic [2:0]         holdoff_reg;
    logic               accept_err_reg;

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // Ready depends on the registered count only: a pop in the same cycle
    // does not open a slot until the following cycle.
    assign host_ready = (count_reg != CNT_W'(DEPTH));
    assign cmd_valid  = (count_reg != '0) && (holdoff_reg == 3'd0);

    assign push = host_valid && host_ready;
    assign pop  = cmd_accept && cmd_valid;

    assign head       = mem_reg[rd_ptr_reg];
    assign cmd_write  = head[ENTRY_W-1];
    assign cmd_addr   = head[16 +: ADDR_W];
    assign cmd_wdata  = head[15:0];
    assign fill_level = count_reg;
    assign accept_err = accept_err_reg;

    // One write port per entry, selected by the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= {host_write, host_addr, host_wdata};
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            holdoff_reg    <= 3'd0;
            accept_err_reg <= 1'b0;
        end else begin
            count_reg <= count_next;

            // DEPTH is a power of two, so pointer wrap is natural overflow.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end

            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
                holdoff_reg <= 3'(HOLDOFF);
            end else if (holdoff_reg != 3'd0) begin
                holdoff_reg <= holdoff_reg - 3'd1;
            end

            // Any accept the queue cannot honour (empty or in holdoff)
            // is latched until reset.
            if (cmd_accept && !cmd_valid) begin
                accept_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_fifo.sv
// Self-checking bench for sdram_cmd_fifo. A queue of expected entries is
// pushed whenever the host handshake completes and popped/compared when the
// controller side consumes the head.
module tb_sdram_cmd_fifo;

    localparam int DEPTH   = 4;
    localparam int HOLDOFF = 2;

    typedef struct packed {
        logic        w;
        logic [23:0] a;
        logic [15:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic        host_write = 1'b0;
    logic [23:0] host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        cmd_valid;
    logic        cmd_write;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        cmd_accept = 1'b0;
    logic [2:0]  fill_level;
    logic        accept_err;

    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    ent_t sb[$];
    int   m_hold = 0;
    bit   m_err  = 1'b0;

    sdram_cmd_fifo #(
        .ROW_BITS(13), .COL_BITS(9), .BANK_BITS(2),
        .DEPTH(DEPTH), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_write(host_write), .host_addr(host_addr), .host_wdata(host_wdata),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_accept(cmd_accept), .fill_level(fill_level),
        .accept_err(accept_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus; updates the model from what the spec says the
    // queue should do given its state before the edge.
    task automatic drive_cycle(input bit hv, input bit hw, input logic [23:0] ha,
                               input logic [15:0] hd, input bit acc);
        bit m_ready, m_valid, do_push, do_pop;
        host_valid = hv; host_write = hw; host_addr = ha; host_wdata = hd;
        cmd_accept = acc;
        m_ready = (sb.size() != DEPTH);
        m_valid = (sb.size() != 0) && (m_hold == 0);
        do_push = hv && m_ready;
        do_pop  = acc && m_valid;
        if (acc && !m_valid) m_err = 1'b1;
        @(posedge clk);
        if (do_pop) begin
            void'(sb.pop_front());
            m_hold = HOLDOFF;
        end else if (m_hold > 0) begin
            m_hold--;
        end
        if (do_push) sb.push_back(ent_t'{w: hw, a: ha, d: hd});
        #1;
        host_valid = 1'b0;
        cmd_accept = 1'b0;
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 24'h0, 16'h0, 1'b0);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        host_valid = 1'b1; host_write = 1'b1;
        host_addr = 24'h55AA55; host_wdata = 16'hBEEF;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        host_valid = 1'b0;
        sb.delete();
        m_hold = 0;
        m_err  = 1'b0;
    endtask

    // Pops everything queued, comparing each head against the scoreboard.
    task automatic drain_and_check(input string tag);
        int wait_cnt;
        ent_t e;
        while (sb.size() > 0) begin
            wait_cnt = 0;
            while (!cmd_valid && wait_cnt < 20) begin
                idle();
                wait_cnt++;
            end
            n_checks++;
            if (!cmd_valid) begin
                n_errors++;
                $display("FAIL %s_wait: cmd_valid=%0b after %0d cycles, required 1", tag, cmd_valid, wait_cnt);
                return;
            end
            e = sb[0];
            n_checks++;
            if ({cmd_write, cmd_addr, cmd_wdata} !== {e.w, e.a, e.d}) begin
                n_errors++;
                $display("FAIL %s_head: got w=%0b a=%h d=%h, required w=%0b a=%h d=%h",
                         tag, cmd_write, cmd_addr, cmd_wdata, e.w, e.a, e.d);
            end else begin
                $display("pop  %s: w=%0b a=%h d=%h", tag, e.w, e.a, e.d);
            end
            drive_cycle(1'b0, 1'b0, 24'h0, 16'h0, 1'b1);
        end
        while (m_hold != 0) idle();
    endtask

    task automatic test_reset();
        apply_reset(2);
        n_checks++;
        if ({cmd_valid, cmd_write, cmd_addr, cmd_wdata} !== 42'h0) begin
            n_errors++;
            $display("FAIL reset_head: got v=%0b w=%0b a=%h d=%h, required all 0",
                     cmd_valid, cmd_write, cmd_addr, cmd_wdata);
        end
        n_checks++;
        if (fill_level !== 3'd0 || accept_err !== 1'b0 || host_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_status: got fill=%0d err=%0b ready=%0b, required 0 0 1",
                     fill_level, accept_err, host_ready);
        end
        idle();
        n_checks++;
        if (fill_level !== 3'd0 || cmd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_nostore: got fill=%0d v=%0b, required 0 0", fill_level, cmd_valid);
        end
        $display("reset: fill=%0d ready=%0b", fill_level, host_ready);
    endtask

    task automatic test_single_write();
        drive_cycle(1'b1, 1'b1, 24'h0ABCDE, 16'h1234, 1'b0);
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_write !== 1'b1 || cmd_addr !== 24'h0ABCDE ||
            cmd_wdata !== 16'h1234 || fill_level !== 3'd1) begin
            n_errors++;
            $display("FAIL single_write: got v=%0b w=%0b a=%h d=%h fill=%0d, required 1 1 0abcde 1234 1",
                     cmd_valid, cmd_write, cmd_addr, cmd_wdata, fill_level);
        end
        $display("push single: a=0abcde d=1234 fill=%0d", fill_level);
        drain_and_check("single");
    endtask

    task automatic test_fill_overflow();
        ent_t e;
        for (int i = 0; i < 5; i++) begin
            e = ent_t'{w: i[0], a: 24'h100000 + 24'(i), d: 16'hA000 + 16'(i)};
            drive_cycle(1'b1, e.w, e.a, e.d, 1'b0);
            $display("push fill %0d: a=%h ready=%0b fill=%0d", i, e.a, host_ready, fill_level);
        end
        n_checks++;
        if (host_ready !== 1'b0 || fill_level !== 3'd4) begin
            n_errors++;
            $display("FAIL full: got ready=%0b fill=%0d, required 0 4", host_ready, fill_level);
        end
        n_checks++;
        if (cmd_addr !== 24'h100000) begin
            n_errors++;
            $display("FAIL full_head: got a=%h, required 100000", cmd_addr);
        end
        // Pop while full with the 5th request still held: no push this edge.
        e = ent_t'{w: 1'b0, a: 24'h100004, d: 16'hA004};
        drive_cycle(1'b1, e.w, e.a, e.d, 1'b1);
        n_checks++;
        if (host_ready !== 1'b1 || fill_level !== 3'd3) begin
            n_errors++;
            $display("FAIL full_pop: got ready=%0b fill=%0d, required 1 3", host_ready, fill_level);
        end
        drive_cycle(1'b1, e.w, e.a, e.d, 1'b0);
        n_checks++;
        if (fill_level !== 3'd4) begin
            n_errors++;
            $display("FAIL fifth_enter: got fill=%0d, required 4", fill_level);
        end
        drain_and_check("fill");
    endtask

    task automatic test_holdoff_wrap();
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 1'b1, 24'h200000 + 24'(i), 16'hB000 + 16'(i), 1'b0);
        drive_cycle(1'b0, 1'b0, 24'h0, 16'h0, 1'b1);
        for (int k = 0; k < HOLDOFF; k++) begin
            n_checks++;
            if (cmd_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL holdoff_low%0d: got v=%0b, required 0", k, cmd_valid);
            end
            idle();
        end
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 24'h200001 || cmd_wdata !== 16'hB001) begin
            n_errors++;
            $display("FAIL holdoff_release: got v=%0b a=%h d=%h, required 1 200001 b001",
                     cmd_valid, cmd_addr, cmd_wdata);
        end
        $display("holdoff: released after %0d cycles, head a=%h", HOLDOFF, cmd_addr);
        drive_cycle(1'b1, 1'b0, 24'h200003, 16'hB003, 1'b0);
        drive_cycle(1'b1, 1'b1, 24'h200004, 16'hB004, 1'b0);
        drain_and_check("wrap");
    endtask

    task automatic test_error();
        drive_cycle(1'b0, 1'b0, 24'h0, 16'h0, 1'b1);
        n_checks++;
        if (accept_err !== 1'b1 || fill_level !== 3'd0) begin
            n_errors++;
            $display("FAIL err_empty: got err=%0b fill=%0d, required 1 0", accept_err, fill_level);
        end
        drive_cycle(1'b1, 1'b0, 24'h300000, 16'hC000, 1'b0);
        drive_cycle(1'b1, 1'b1, 24'h300001, 16'hC001, 1'b0);
        drive_cycle(1'b0, 1'b0, 24'h0, 16'h0, 1'b1);
        drive_cycle(1'b0, 1'b0, 24'h0, 16'h0, 1'b1);
        n_checks++;
        if (accept_err !== 1'b1 || fill_level !== 3'd1) begin
            n_errors++;
            $display("FAIL err_holdoff: got err=%0b fill=%0d, required 1 1", accept_err, fill_level);
        end
        while (m_hold != 0) idle();
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 24'h300001) begin
            n_errors++;
            $display("FAIL err_ptr: got v=%0b a=%h, required 1 300001", cmd_valid, cmd_addr);
        end
        drain_and_check("err");
        n_checks++;
        if (accept_err !== m_err) begin
            n_errors++;
            $display("FAIL err_sticky: got err=%0b, required %0b", accept_err, m_err);
        end
        $display("error: accept_err=%0b fill=%0d", accept_err, fill_level);
    endtask

    task automatic test_simultaneous();
        drive_cycle(1'b1, 1'b1, 24'h400000, 16'hD000, 1'b0);
        drive_cycle(1'b1, 1'b0, 24'h400001, 16'hD001, 1'b1);
        n_checks++;
        if (fill_level !== 3'd1 || cmd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_pushpop: got fill=%0d v=%0b, required 1 0", fill_level, cmd_valid);
        end
        repeat (HOLDOFF) idle();
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 24'h400001 || cmd_write !== 1'b0) begin
            n_errors++;
            $display("FAIL simul_head: got v=%0b w=%0b a=%h, required 1 0 400001",
                     cmd_valid, cmd_write, cmd_addr);
        end
        drain_and_check("simul");

        // Empty queue: push and accept on the same edge.
        apply_reset(1);
        drive_cycle(1'b1, 1'b1, 24'h500000, 16'hE000, 1'b1);
        n_checks++;
        if (accept_err !== 1'b1 || fill_level !== 3'd1 || cmd_valid !== 1'b1 ||
            cmd_addr !== 24'h500000) begin
            n_errors++;
            $display("FAIL empty_pushacc: got err=%0b fill=%0d v=%0b a=%h, required 1 1 1 500000",
                     accept_err, fill_level, cmd_valid, cmd_addr);
        end
        drive_cycle(1'b1, 1'b0, 24'h500001, 16'hE001, 1'b0);
        drive_cycle(1'b1, 1'b1, 24'h500002, 16'hE002, 1'b0);
        n_checks++;
        if (fill_level !== 3'd3) begin
            n_errors++;
            $display("FAIL pre_reset: got fill=%0d, required 3", fill_level);
        end
        apply_reset(1);
        n_checks++;
        if (fill_level !== 3'd0 || cmd_valid !== 1'b0 || host_ready !== 1'b1 ||
            accept_err !== 1'b0 || cmd_addr !== 24'h0) begin
            n_errors++;
            $display("FAIL mid_reset: got fill=%0d v=%0b ready=%0b err=%0b a=%h, required 0 0 1 0 0",
                     fill_level, cmd_valid, host_ready, accept_err, cmd_addr);
        end
        $display("simultaneous: after reset fill=%0d v=%0b", fill_level, cmd_valid);
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_write();
        test_fill_overflow();
        test_holdoff_wrap();
        test_error();
        test_simultaneous();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
